// File: rtl/cla_pkg.sv
// Shared types and helpers for the multi-beat carry-lookahead add/subtract sequencer.
// Optional flag outputs are enabled elsewhere by the CLA_SEQ_FLAGS_EN macro.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_DEFAULT = 8;

  // Beat counter width; a single-beat configuration still needs one bit.
  function automatic int clog2_beats(input int beats);
    return (beats > 2) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/cla_add_sequencer_if.sv
// Request/result handshake bundle for cla_add_sequencer.
// ovf/zero exist only when CLA_SEQ_FLAGS_EN is defined.
interface cla_add_sequencer_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef CLA_SEQ_FLAGS_EN
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero
  );
`else
  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, sum, c_out
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, sum, c_out
  );
`endif

endinterface

// File: rtl/cla_slice.sv
// SLICE-bit combinational carry-lookahead adder built from 4-bit lookahead groups.
// Group carries chain from one group to the next.
module cla_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] s,
  output logic             c_out
);

  localparam int GROUPS = SLICE / 4;

  logic [SLICE-1:0] g_s;
  logic [SLICE-1:0] p_s;
  logic [SLICE-1:0] c_s;
  logic [3:0]       gg_s;
  logic [3:0]       pp_s;
  logic             carry_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Per-group lookahead carries; each group's carry-out feeds the next group.
  always_comb begin
    c_s     = '0;
    gg_s    = 4'b0000;
    pp_s    = 4'b0000;
    carry_s = c_in;
    for (int k = 0; k < GROUPS; k++) begin
      gg_s = g_s[4*k +: 4];
      pp_s = p_s[4*k +: 4];
      c_s[4*k]   = carry_s;
      c_s[4*k+1] = gg_s[0] | (pp_s[0] & carry_s);
      c_s[4*k+2] = gg_s[1] | (pp_s[1] & gg_s[0]) | (pp_s[1] & pp_s[0] & carry_s);
      c_s[4*k+3] = gg_s[2] | (pp_s[2] & gg_s[1]) | (pp_s[2] & pp_s[1] & gg_s[0])
                 | (pp_s[2] & pp_s[1] & pp_s[0] & carry_s);
      carry_s    = gg_s[3] | (pp_s[3] & gg_s[2]) | (pp_s[3] & pp_s[2] & gg_s[1])
                 | (pp_s[3] & pp_s[2] & pp_s[1] & gg_s[0]) | ((&pp_s) & carry_s);
    end
  end

  assign s     = p_s ^ c_s;
  assign c_out = carry_s;

endmodule

// File: rtl/cla_add_sequencer.sv
// Multi-beat add/subtract controller: one CLA slice sequenced over WIDTH/SLICE beats.
// Define CLA_SEQ_FLAGS_EN to add the ovf/zero result flags.
module cla_add_sequencer
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  cla_add_sequencer_if.slave bus
);

  localparam int             BEATS     = WIDTH / SLICE;
  localparam int             CW        = clog2_beats(BEATS);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(BEATS - 1);
  localparam logic [1:0]     ST_IDLE   = 2'(IDLE);
  localparam logic [1:0]     ST_RUN    = 2'(RUN);
  localparam logic [1:0]     ST_DONE   = 2'(DONE);

  logic [1:0]       state_r;
  logic [CW-1:0]    beat_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
`ifdef CLA_SEQ_FLAGS_EN
  logic             ovf_r;
  logic             zero_r;
`endif

  logic [SLICE-1:0] slice_a_s;
  logic [SLICE-1:0] slice_b_s;
  logic [SLICE-1:0] slice_s_s;
  logic             slice_c_s;
  logic [WIDTH-1:0] sum_next_s;

  // Select the current beat's operand fields and merge the slice result into the sum.
  always_comb begin
    slice_a_s  = a_r[SLICE*int'(beat_r) +: SLICE];
    slice_b_s  = b_r[SLICE*int'(beat_r) +: SLICE];
    sum_next_s = sum_r;
    sum_next_s[SLICE*int'(beat_r) +: SLICE] = slice_s_s;
  end

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a     (slice_a_s),
    .b     (slice_b_s),
    .c_in  (carry_r),
    .s     (slice_s_s),
    .c_out (slice_c_s)
  );

  // Sequencer FSM, operand latches and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      beat_r  <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
`ifdef CLA_SEQ_FLAGS_EN
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_r <= ST_RUN;
            beat_r  <= '0;
            a_r     <= bus.op_a;
            // Subtraction is A + ~B + 1, so the inverted B and carry-in are latched here.
            b_r     <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_r <= bus.sub;
            sum_r   <= '0;
            c_out_r <= 1'b0;
`ifdef CLA_SEQ_FLAGS_EN
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_r   <= sum_next_s;
          carry_r <= slice_c_s;
          if (beat_r == LAST_BEAT) begin
            state_r <= ST_DONE;
            beat_r  <= '0;
            c_out_r <= slice_c_s;
`ifdef CLA_SEQ_FLAGS_EN
            ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (sum_next_s[WIDTH-1] != a_r[WIDTH-1]);
            zero_r  <= (sum_next_s == '0);
`endif
          end else begin
            beat_r  <= beat_r + CW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.out_valid = (state_r == ST_DONE);
  assign bus.sum       = sum_r;
  assign bus.c_out     = c_out_r;
`ifdef CLA_SEQ_FLAGS_EN
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;
`endif

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Self-checking bench for cla_add_sequencer (WIDTH=32, SLICE=8) against an arithmetic reference.
// Flag checks are compiled in only when CLA_SEQ_FLAGS_EN is defined.
module tb_cla_add_sequencer;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int BEATS = WIDTH / SLICE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  cla_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  cla_add_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain WIDTH+1-bit arithmetic, with true signed range for overflow.
  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [32:0] bb;
    bb = s ? {1'b0, ~b} : {1'b0, b};
    return {1'b0, a} + bb + {32'd0, s};
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    longint t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = s ? (sa - sb) : (sa + sb);
    return (t > 64'sd2147483647) || (t < -64'sd2147483648);
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int hold, input logic use_exp,
                        input logic [31:0] exp_sum, input logic exp_c);
    int          cyc;
    logic [32:0] r;
    r   = ref_sum(a, b, s);
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    bus.sub      = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(BEATS + 1));
    check({tag, " sum"}, 64'(bus.sum), 64'(r[31:0]));
    check({tag, " c_out"}, 64'(bus.c_out), 64'(r[32]));
    if (use_exp) begin
      check({tag, " sum_const"}, 64'({bus.c_out, bus.sum}), 64'({exp_c, exp_sum}));
    end
`ifdef CLA_SEQ_FLAGS_EN
    check({tag, " zero"}, 64'(bus.zero), 64'(r[31:0] == 32'd0));
    check({tag, " ovf"}, 64'(bus.ovf), 64'(ref_ovf(a, b, s)));
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.op_a     = $urandom;
      tick();
      check({tag, " hold"}, 64'({bus.out_valid, bus.in_ready, bus.c_out, bus.sum}),
            64'({1'b1, 1'b0, r[32], r[31:0]}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " handoff"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bus.in_valid  = 1'b0;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({bus.in_ready, bus.out_valid, bus.c_out, bus.sum}), 64'({1'b1, 1'b0, 1'b0, 32'd0}));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_hold", 64'({bus.in_ready, bus.out_valid, bus.c_out, bus.sum}), 64'({1'b1, 1'b0, 1'b0, 32'd0}));
    end

    run_op("ff_plus_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 1'b1, 32'h0000_0100, 1'b0);
    run_op("ripple_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b1, 32'h0000_0000, 1'b1);
    run_op("sub_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b1, 32'h8000_0000, 1'b0);
    run_op("backpressure", 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 7, 1'b0, 32'd0, 1'b0);

    // Abort in beat 2: two RUN beats have written partial result fields.
    bus.op_a     = 32'h1122_3344;
    bus.op_b     = 32'h0101_0101;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 64'({bus.in_ready, bus.out_valid, bus.c_out, bus.sum}), 64'({1'b1, 1'b0, 1'b0, 32'd0}));
`ifdef CLA_SEQ_FLAGS_EN
    check("async_reset_flags", 64'({bus.ovf, bus.zero}), 64'(2'b00));
`endif
    tick();
    check("reset_held", 64'({bus.in_ready, bus.out_valid, bus.sum}), 64'({1'b1, 1'b0, 32'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("five_minus_three", 32'd5, 32'd3, 1'b1, 0, 1'b1, 32'd2, 1'b1);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = (i % 4 == 3) ? ra : $urandom;
      run_op("random", ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
